fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_if.sv | 35 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Optional feature macro: FIFO_ARB_TAG_EN (prefixes written words with grant_id).
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int b);
    return $clog2(b) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake plus FIFO write-port bundle for fifo_wr_arbiter.
// With FIFO_ARB_TAG_EN defined the write data carries grant_id above the payload.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = id_w(NUM_REQ);
`ifdef FIFO_ARB_TAG_EN
  localparam int OUT_W = WIDTH + ID_W;
`else
  localparam int OUT_W = WIDTH;
`endif

  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_rdy;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [OUT_W-1:0]         fifo_wr_data;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  modport master (
    input  req_vld, req_data, fifo_full,
    output req_rdy, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    output req_vld, req_data, fifo_full,
    input  req_rdy, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from base upward, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          any,
  output logic [IW-1:0] idx
);
  localparam int unsigned NU = N;

  int unsigned     cand;
  logic [IW-1:0]   cand_idx;

  always_comb begin
    any      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      cand     = (int'(base) + i) % NU;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional FIFO_ARB_TAG_EN: fifo_wr_data = {grant_id, payload}.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int BURST   = 4
) (
  input  logic               clk,
  input  logic               rest_n,
  fifo_wr_arbiter_if.master  bus
);
  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = cnt_w(BURST);
`ifdef FIFO_ARB_TAG_EN
  localparam int OUT_W = WIDTH + ID_W;
`else
  localparam int OUT_W = WIDTH;
`endif

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   grant_id, grant_id_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              g_vld;
  logic [WIDTH-1:0]  g_data;
  logic [NUM_REQ-1:0] req_rdy_c;
  logic              wr_en_c;
  logic [OUT_W-1:0]  wr_data_c;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req  (bus.req_vld),
    .base (rr_ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    g_vld  = 1'b0;
    g_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        g_vld  = bus.req_vld[i];
        g_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_id_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_id_nxt = grant_id;
    beat_cnt_nxt = beat_cnt;
    req_rdy_c    = '0;
    wr_en_c      = 1'b0;
    wr_data_c    = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt    = ARB_GRANT;
          grant_id_nxt = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      ARB_GRANT: begin
        req_rdy_c[grant_id] = ~bus.fifo_full;
        wr_en_c             = g_vld & ~bus.fifo_full;
`ifdef FIFO_ARB_TAG_EN
        wr_data_c = {grant_id, g_data};
`else
        wr_data_c = g_data;
`endif
        if (wr_en_c) beat_cnt_nxt = beat_cnt + 1'b1;
        // A full FIFO freezes the grant even if the owner's valid drops.
        if ((wr_en_c && beat_cnt == CNT_W'(BURST-1)) || (!g_vld && !bus.fifo_full)) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign bus.req_rdy      = req_rdy_c;
  assign bus.fifo_wr_en   = wr_en_c;
  assign bus.fifo_wr_data = wr_data_c;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = (state == ARB_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, reset abort, and randomized traffic vs a reference model.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int BU = 4;
`ifdef FIFO_ARB_TAG_EN
  localparam int OUT_W = W + 2;
  localparam logic [OUT_W-1:0] TAG_EXP = 10'h2A5;
`else
  localparam int OUT_W = W;
  localparam logic [OUT_W-1:0] TAG_EXP = 8'hA5;
`endif

  logic clk = 1'b0;
  logic rest_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .BURST(BU)) dut (
    .clk    (clk),
    .rest_n (rest_n),
    .bus    (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_out(input int gid, input logic [W-1:0] d);
    logic [1:0] g;
    g = gid[1:0];
`ifdef FIFO_ARB_TAG_EN
    return {g, d};
`else
    return d;
`endif
  endfunction

  typedef struct {
    logic [3:0] vld;
    logic       full;
    logic [3:0] d;
    logic [3:0] rdy;
    logic       wen;
    logic       busy;
    logic [1:0] gid;
  } row_t;

  row_t rows[24];

  // Reference model state: transaction-level view of ownership.
  bit         m_busy;
  int         m_owner;
  int         m_beats;
  int         m_next;
  logic [7:0] q[NR][$];
  int         order_q[$];
  int         p_vld, p_full;

  task automatic drive_random();
    for (int i = 0; i < NR; i++) begin
      bus.req_vld[i] = (q[i].size() > 0) && ($urandom_range(0, 99) < p_vld);
      bus.req_data[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 8'($urandom);
    end
    bus.fifo_full = ($urandom_range(0, 99) < p_full);
  endtask

  task automatic model_step(output logic [3:0] acc);
    logic [3:0] vld;
    logic       full;
    logic [3:0] exp_rdy;
    logic       exp_wen;
    bit         found;
    int         j;
    vld  = bus.req_vld;
    full = bus.fifo_full;
    acc  = '0;
    if (!m_busy) begin
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_wen", 32'(bus.fifo_wr_en), 0);
      chk("idle_rdy", 32'(bus.req_rdy), 0);
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        j = (m_next + k) % NR;
        if (!found && vld[j]) begin
          found   = 1'b1;
          m_owner = j;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else begin
      exp_rdy = full ? 4'b0000 : (4'b0001 << m_owner);
      exp_wen = vld[m_owner] && !full;
      chk("rnd_busy", 32'(bus.busy), 1);
      chk("rnd_gid", 32'(bus.grant_id), 32'(m_owner));
      chk("rnd_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
      chk("rnd_wen", 32'(bus.fifo_wr_en), 32'(exp_wen));
      if (exp_wen) begin
        chk("rnd_data", 32'(bus.fifo_wr_data), 32'(exp_out(m_owner, q[m_owner][0])));
        acc[m_owner] = 1'b1;
        m_beats++;
        order_q.push_back(m_owner);
      end
      if ((exp_wen && m_beats == BU) || (!vld[m_owner] && !full)) begin
        m_busy = 1'b0;
        m_next = (m_owner + 1) % NR;
      end
    end
  endtask

  task automatic run_random(input int cycles, input bit refill);
    logic [3:0] acc;
    acc = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NR; i++)
        if (acc[i]) void'(q[i].pop_front());
      if (refill)
        for (int i = 0; i < NR; i++)
          if (q[i].size() < 3)
            for (int n = 0; n < 5; n++) q[i].push_back(8'($urandom));
      drive_random();
      @(negedge clk);
      model_step(acc);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < NR; i++)
      if (acc[i]) void'(q[i].pop_front());
  endtask

  initial begin
    rows = '{
      '{4'b0010, 1'b0, 4'h1, 4'b0000, 1'b0, 1'b0, 2'd0},
      '{4'b0010, 1'b0, 4'h1, 4'b0010, 1'b1, 1'b1, 2'd1},
      '{4'b0010, 1'b0, 4'h2, 4'b0010, 1'b1, 1'b1, 2'd1},
      '{4'b0010, 1'b0, 4'h3, 4'b0010, 1'b1, 1'b1, 2'd1},
      '{4'b0010, 1'b0, 4'h4, 4'b0010, 1'b1, 1'b1, 2'd1},
      '{4'b0010, 1'b0, 4'h5, 4'b0000, 1'b0, 1'b0, 2'd1},
      '{4'b0010, 1'b0, 4'h5, 4'b0010, 1'b1, 1'b1, 2'd1},
      '{4'b0010, 1'b0, 4'h6, 4'b0010, 1'b1, 1'b1, 2'd1},
      '{4'b0010, 1'b0, 4'h7, 4'b0010, 1'b1, 1'b1, 2'd1},
      '{4'b0010, 1'b0, 4'h8, 4'b0010, 1'b1, 1'b1, 2'd1},
      '{4'b0100, 1'b0, 4'h9, 4'b0000, 1'b0, 1'b0, 2'd1},
      '{4'b0100, 1'b0, 4'h9, 4'b0100, 1'b1, 1'b1, 2'd2},
      '{4'b0100, 1'b0, 4'hA, 4'b0100, 1'b1, 1'b1, 2'd2},
      '{4'b0100, 1'b1, 4'hA, 4'b0000, 1'b0, 1'b1, 2'd2},
      '{4'b0000, 1'b1, 4'hA, 4'b0000, 1'b0, 1'b1, 2'd2},
      '{4'b0100, 1'b1, 4'hA, 4'b0000, 1'b0, 1'b1, 2'd2},
      '{4'b0100, 1'b0, 4'hB, 4'b0100, 1'b1, 1'b1, 2'd2},
      '{4'b0100, 1'b0, 4'hC, 4'b0100, 1'b1, 1'b1, 2'd2},
      '{4'b0001, 1'b0, 4'hD, 4'b0000, 1'b0, 1'b0, 2'd2},
      '{4'b0001, 1'b0, 4'hD, 4'b0001, 1'b1, 1'b1, 2'd0},
      '{4'b0001, 1'b0, 4'hE, 4'b0001, 1'b1, 1'b1, 2'd0},
      '{4'b0000, 1'b0, 4'hE, 4'b0001, 1'b0, 1'b1, 2'd0},
      '{4'b1111, 1'b0, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0},
      '{4'b1111, 1'b0, 4'hF, 4'b0010, 1'b1, 1'b1, 2'd1}
    };

    // Reset with every requester asking.
    rest_n        = 1'b0;
    bus.req_vld   = 4'b1111;
    bus.req_data  = 32'h44332211;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(bus.req_rdy), 0);
    chk("rst_wen", 32'(bus.fifo_wr_en), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_gid", 32'(bus.grant_id), 0);
    chk("rst_data", 32'(bus.fifo_wr_data), 0);
    bus.req_vld = '0;
    rest_n      = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: solo streaming, back-pressure, early release, pointer advance.
    for (int r = 0; r < 24; r++) begin
      bus.req_vld   = rows[r].vld;
      bus.fifo_full = rows[r].full;
      for (int i = 0; i < NR; i++) bus.req_data[i*W +: W] = {4'(i), rows[r].d};
      @(negedge clk);
      chk($sformatf("row%0d_rdy", r), 32'(bus.req_rdy), 32'(rows[r].rdy));
      chk($sformatf("row%0d_wen", r), 32'(bus.fifo_wr_en), 32'(rows[r].wen));
      chk($sformatf("row%0d_busy", r), 32'(bus.busy), 32'(rows[r].busy));
      chk($sformatf("row%0d_gid", r), 32'(bus.grant_id), 32'(rows[r].gid));
      chk($sformatf("row%0d_data", r), 32'(bus.fifo_wr_data),
          rows[r].busy ? 32'(exp_out(int'(rows[r].gid), {2'b00, rows[r].gid, rows[r].d})) : 32'd0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a burst.
    rest_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_wen", 32'(bus.fifo_wr_en), 0);
    chk("abort_rdy", 32'(bus.req_rdy), 0);
    chk("abort_gid", 32'(bus.grant_id), 0);
    bus.req_vld = '0;
    @(negedge clk);
    rest_n  = 1'b1;
    m_busy  = 1'b0;
    m_next  = 0;
    m_owner = 0;
    m_beats = 0;
    @(posedge clk);
    #1;

    // All requesters continuously valid: strict rotation with full bursts.
    for (int i = 0; i < NR; i++)
      for (int n = 0; n < 12; n++) q[i].push_back(8'($urandom));
    p_vld  = 100;
    p_full = 0;
    run_random(70, 1'b0);
    chk("rr_words", 32'(order_q.size()), 48);
    for (int k = 0; k < order_q.size() && k < 48; k++)
      chk($sformatf("rr_owner%0d", k), 32'(order_q[k]), 32'((k / BU) % NR));

    // Random valid gaps and back-pressure.
    p_vld  = 70;
    p_full = 25;
    run_random(400, 1'b1);

    // Tag/untagged data format for requester 2.
    rest_n = 1'b0;
    bus.req_vld = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    rest_n = 1'b1;
    bus.req_vld = 4'b0100;
    bus.req_data[2*W +: W] = 8'hA5;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("tag_gid", 32'(bus.grant_id), 2);
    chk("tag_wen", 32'(bus.fifo_wr_en), 1);
    chk("tag_data", 32'(bus.fifo_wr_data), 32'(TAG_EXP));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
